// File: rtl/complex_divider_35_17.sv
// Iterative complex divider a = p/b: one multiply cycle, then two 19-step restoring
// dividers running in parallel. Optional build macro CDIV_ROUND_EN selects round-half-away.
module complex_divider_35_17 (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic signed [34:0] i_pr,
    input  logic signed [34:0] i_pi,
    input  logic signed [16:0] i_br,
    input  logic signed [16:0] i_bi,
    output logic signed [17:0] o_ar,
    output logic signed [17:0] o_ai,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_div0
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [34:0] pr_q, pr_d, pi_q, pi_d;
    logic signed [16:0] br_q, br_d, bi_q, bi_d;
    logic [33:0]        den_q, den_d;
    logic [53:0]        rem_r_q, rem_r_d, rem_i_q, rem_i_d;
    logic [52:0]        dsh_q, dsh_d;
    logic [18:0]        quo_r_q, quo_r_d, quo_i_q, quo_i_d;
    logic               ovf_r_q, ovf_r_d, ovf_i_q, ovf_i_d;
    logic               neg_r_q, neg_r_d, neg_i_q, neg_i_d;
    logic signed [17:0] ar_q, ar_d, ai_q, ai_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               div0_q, div0_d;

    logic signed [52:0] prr_c, pii_c, pir_c, pri_c, nr_c, ni_c;
    logic signed [33:0] sq_r_c, sq_i_c;
    logic [33:0]        den_c;
    logic [52:0]        abs_r_c, abs_i_c;
    logic [53:0]        rnd_c, mag_r_c, mag_i_c;
    logic               ge_r_c, ge_i_c;

    // Clamp a 19-bit magnitude into the signed 18-bit range and apply the sign.
    function automatic logic [17:0] sat_q(input logic [18:0] q, input logic ovf, input logic neg);
        logic [18:0] nq;
        nq = 19'd0 - q;
        if (neg) begin
            if (ovf || q > 19'd131072)
                sat_q = 18'h20000;
            else
                sat_q = nq[17:0];
        end else begin
            if (ovf || q > 19'd131071)
                sat_q = 18'h1FFFF;
            else
                sat_q = q[17:0];
        end
    endfunction

    always_comb begin
        prr_c   = 53'(pr_q) * 53'(br_q);
        pii_c   = 53'(pi_q) * 53'(bi_q);
        pir_c   = 53'(pi_q) * 53'(br_q);
        pri_c   = 53'(pr_q) * 53'(bi_q);
        nr_c    = prr_c + pii_c;
        ni_c    = pir_c - pri_c;
        sq_r_c  = 34'(br_q) * 34'(br_q);
        sq_i_c  = 34'(bi_q) * 34'(bi_q);
        den_c   = sq_r_c + sq_i_c;
        abs_r_c = nr_c[52] ? 53'(-nr_c) : 53'(nr_c);
        abs_i_c = ni_c[52] ? 53'(-ni_c) : 53'(ni_c);
`ifdef CDIV_ROUND_EN
        rnd_c   = {21'd0, den_c[33:1]};
`else
        rnd_c   = '0;
`endif
        mag_r_c = {1'b0, abs_r_c} + rnd_c;
        mag_i_c = {1'b0, abs_i_c} + rnd_c;
        ge_r_c  = rem_r_q >= {1'b0, dsh_q};
        ge_i_c  = rem_i_q >= {1'b0, dsh_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        pi_d    = pi_q;
        br_d    = br_q;
        bi_d    = bi_q;
        den_d   = den_q;
        rem_r_d = rem_r_q;
        rem_i_d = rem_i_q;
        dsh_d   = dsh_q;
        quo_r_d = quo_r_q;
        quo_i_d = quo_i_q;
        ovf_r_d = ovf_r_q;
        ovf_i_d = ovf_i_q;
        neg_r_d = neg_r_q;
        neg_i_d = neg_i_q;
        ar_d    = ar_q;
        ai_d    = ai_q;
        div0_d  = div0_q;
        valid_d = 1'b0;
        // Busy covers the o_valid cycle; the FSM is already idle then, so a
        // request presented during that cycle is taken on the following edge.
        busy_d  = busy_q & ~valid_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    pr_d    = i_pr;
                    pi_d    = i_pi;
                    br_d    = i_br;
                    bi_d    = i_bi;
                    busy_d  = 1'b1;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                den_d   = den_c;
                neg_r_d = nr_c[52];
                neg_i_d = ni_c[52];
                rem_r_d = mag_r_c;
                rem_i_d = mag_i_c;
                dsh_d   = {1'b0, den_c, 18'd0};
                quo_r_d = '0;
                quo_i_d = '0;
                ovf_r_d = 1'b0;
                ovf_i_d = 1'b0;
                cnt_d   = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                // First step: a dividend of den*2^19 or more cannot fit 19 quotient bits.
                if (cnt_q == 5'd0) begin
                    ovf_r_d = rem_r_q >= {dsh_q, 1'b0};
                    ovf_i_d = rem_i_q >= {dsh_q, 1'b0};
                end
                rem_r_d = ge_r_c ? rem_r_q - {1'b0, dsh_q} : rem_r_q;
                rem_i_d = ge_i_c ? rem_i_q - {1'b0, dsh_q} : rem_i_q;
                quo_r_d = {quo_r_q[17:0], ge_r_c};
                quo_i_d = {quo_i_q[17:0], ge_i_c};
                dsh_d   = dsh_q >> 1;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd18)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (den_q == 34'd0) begin
                    ar_d   = '0;
                    ai_d   = '0;
                    div0_d = 1'b1;
                end else begin
                    ar_d   = sat_q(quo_r_q, ovf_r_q, neg_r_q);
                    ai_d   = sat_q(quo_i_q, ovf_i_q, neg_i_q);
                    div0_d = 1'b0;
                end
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            pi_q    <= '0;
            br_q    <= '0;
            bi_q    <= '0;
            den_q   <= '0;
            rem_r_q <= '0;
            rem_i_q <= '0;
            dsh_q   <= '0;
            quo_r_q <= '0;
            quo_i_q <= '0;
            ovf_r_q <= 1'b0;
            ovf_i_q <= 1'b0;
            neg_r_q <= 1'b0;
            neg_i_q <= 1'b0;
            ar_q    <= '0;
            ai_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            pi_q    <= pi_d;
            br_q    <= br_d;
            bi_q    <= bi_d;
            den_q   <= den_d;
            rem_r_q <= rem_r_d;
            rem_i_q <= rem_i_d;
            dsh_q   <= dsh_d;
            quo_r_q <= quo_r_d;
            quo_i_q <= quo_i_d;
            ovf_r_q <= ovf_r_d;
            ovf_i_q <= ovf_i_d;
            neg_r_q <= neg_r_d;
            neg_i_q <= neg_i_d;
            ar_q    <= ar_d;
            ai_q    <= ai_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            div0_q  <= div0_d;
        end
    end

    assign o_ar    = ar_q;
    assign o_ai    = ai_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_div0  = div0_q;

endmodule
